muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative 24-bit multiply/divide execution unit sitting directly downstream of the register file. It captures the two read operands (rd1, rd2) and a destination register index, runs a fixed-latency shift-add multiply or restoring divide, and returns the result plus a write-enable pulse to the register-file write port (wd3/we3/ra4). The pipeline control holds the PC while `busy` is high.

## Interface
Parameters:
- WIDTH, 24, operand/result width; the whole spec is written for 24.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  2  00 MUL (low 24 bits), 01 MULH (unsigned high 24 bits), 10 DIVU quotient, 11 REMU remainder.
- a  in  24  operand A (dividend / multiplicand), from rd1.
- b  in  24  operand B (divisor / multiplier), from rd2.
- rd_in  in  4  destination register index.
- busy  out  1  high while computing (state RUN).
- done  out  1  one-cycle pulse (state DONE); drives we3.
- result  out  24  registered result; drives wd3.
- rd_out  out  4  captured destination; drives ra4.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1, capture a, b, op, rd_in; clear 48-bit accumulator and 5-bit counter; go to RUN. Otherwise stay.
- RUN: one iteration per cycle; counter increments 0..23; when counter=23 the last iteration completes and the state goes to DONE.
- DONE: done=1 for exactly one cycle; next state IDLE unconditionally.
- start is ignored in RUN and DONE; no queueing. Operand inputs are don't-care after capture.
- Multiply: unsigned shift-add on the 48-bit product. MUL returns product[23:0]; MULH returns product[47:24].
- Divide: unsigned restoring divide, one quotient bit per iteration, MSB first; 25-bit partial remainder.
- Divide by zero (b=0): no special path; the restoring algorithm yields DIVU = 24'hFFFFFF and REMU = a. This is required behaviour.
- result and rd_out update only on the edge entering DONE and hold their values until the next DONE.
- Reset: state IDLE, busy=0, done=0, result=0, rd_out=0, accumulator/counter cleared. rst has priority over start and over any state, including mid-RUN (the operation is discarded and no done is produced).

## Timing
- start sampled at edge k → busy=1 after edge k.
- Latency: done=1 during the cycle after edge k+24, deasserted after edge k+25; busy drops after edge k+24.
- Fixed latency of 25 cycles for every op, including divide by zero.
- result/rd_out are stable for the whole done cycle, so the register file's falling-edge write captures them safely.
- Earliest next accepted start: edge k+26 (first IDLE cycle).
- done and busy are never high simultaneously.

## Configuration
- Macro MULDIV_DIV_EN.
- Defined: divide datapath present; ops 10/11 behave as specified.
- Undefined: divider logic not compiled in; ops 10/11 still go through IDLE→RUN→DONE with identical 25-cycle timing and return result=24'h000000; rd_out is still captured and done still pulses. MUL/MULH unaffected.

## Test plan
- MUL a=3, b=5, rd_in=4 → done 25 cycles after start; result=24'h00000F, rd_out=4; busy high for exactly 24 cycles.
- MULH a=b=24'hFFFFFF → result=24'hFFFFFE; MUL with the same operands → 24'h000001.
- DIVU a=100, b=7 → 14 (24'h00000E); REMU with the same operands → 2; with MULDIV_DIV_EN undefined both return 0 with the same timing.
- DIVU a=24'h123456, b=0 → 24'hFFFFFF; REMU a=24'h123456, b=0 → 24'h123456.
- Start a MUL, assert rst for one cycle at the 10th RUN cycle → next cycle busy=0, done=0, result=0; no done pulse follows; a new start afterwards completes normally.
- Hold start=1 continuously and change a/b during RUN → only the first request is processed with its captured operands; the next is accepted at edge k+26, giving done pulses spaced 26 cycles apart.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative 24-bit multiply/divide unit: shift-add MUL/MULH, restoring DIVU/REMU, fixed 25-cycle latency.
// Define MULDIV_DIV_EN to build the divider; without it ops 10/11 return zero with identical timing.
module muldiv_unit #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       rd_out
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nx;
  logic [2*WIDTH-1:0] acc, acc_nx;
  logic [WIDTH-1:0]   areg, breg, res_nx;
  logic [1:0]         opreg;
  logic [3:0]         rdreg;
  logic [4:0]         cnt;
  logic               last;

  assign last = (cnt == 5'(WIDTH-1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef MULDIV_DIV_EN
  // 25-bit trial value: partial remainder shifted left with the next dividend bit.
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_sub;
`endif

  // acc holds the product for multiplies, {remainder, quotient} for divides.
  always_comb begin
    acc_nx = acc;
`ifdef MULDIV_DIV_EN
    trial   = {acc[2*WIDTH-1:WIDTH], areg[WIDTH-1]};
    rem_sub = trial[WIDTH-1:0] - breg;
`endif
    if (!opreg[1]) begin
      acc_nx = {acc[2*WIDTH-2:0], 1'b0} + (breg[WIDTH-1] ? {{WIDTH{1'b0}}, areg} : '0);
    end
`ifdef MULDIV_DIV_EN
    else if (trial >= {1'b0, breg}) begin
      acc_nx = {rem_sub, acc[WIDTH-2:0], 1'b1};
    end else begin
      acc_nx = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
`endif
  end

`ifdef MULDIV_DIV_EN
  assign res_nx = opreg[0] ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0];
`else
  assign res_nx = opreg[1] ? '0 : (opreg[0] ? acc_nx[2*WIDTH-1:WIDTH] : acc_nx[WIDTH-1:0]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      cnt    <= '0;
      areg   <= '0;
      breg   <= '0;
      opreg  <= '0;
      rdreg  <= '0;
      result <= '0;
      rd_out <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          acc   <= '0;
          cnt   <= '0;
          areg  <= a;
          breg  <= b;
          opreg <= op;
          rdreg <= rd_in;
        end
        RUN: begin
          acc <= acc_nx;
          cnt <= cnt + 5'd1;
          // Multiplier bits and dividend bits are both consumed MSB first.
          if (opreg[1]) areg <= {areg[WIDTH-2:0], 1'b0};
          else          breg <= {breg[WIDTH-2:0], 1'b0};
          if (last) begin
            result <= res_nx;
            rd_out <= rdreg;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, results, reset abort and held-start spacing.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [23:0] a, b;
  logic [3:0]  rd_in;
  logic        busy, done;
  logic [23:0] result;
  logic [3:0]  rd_out;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  muldiv_unit #(.WIDTH(24)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .rd_in(rd_in),
    .busy(busy), .done(done), .result(result), .rd_out(rd_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Waits (bounded) at negedges for done; returns the cycle count at that point.
  task automatic wait_done(input string tag, output int t);
    int n;
    n = 0;
    while (!done && n < 60) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
    if (!done) check({tag, "_timeout"}, 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [23:0] va,
                        input logic [23:0] vb, input logic [3:0] rd, input logic [23:0] exp);
    int lat, bcnt;
    @(negedge clk);
    start = 1'b1; op = o; a = va; b = vb; rd_in = rd;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = 24'h5A5A5A; b = 24'hA5A5A5; rd_in = 4'hF;
    check({tag, "_busy0"}, {31'd0, busy}, 32'd1);
    lat = 0; bcnt = 0;
    while (!done && lat < 40) begin
      if (busy) bcnt++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 32'd24);
    check({tag, "_busy_cycles"}, bcnt, 32'd24);
    check({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_result"}, {8'd0, result}, {8'd0, exp});
    check({tag, "_rd_out"}, {28'd0, rd_out}, {28'd0, rd});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_off"}, {31'd0, done}, 32'd0);
    check({tag, "_result_hold"}, {8'd0, result}, {8'd0, exp});
  endtask

  initial begin
    int t1, t2, dcnt;
    rst = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0; rd_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", {8'd0, result}, 32'd0);
    check("reset_rd_out", {28'd0, rd_out}, 32'd0);

    run_op("mul_3x5", 2'b00, 24'd3, 24'd5, 4'd4, 24'h00000F);
    run_op("mulh_ff", 2'b01, 24'hFFFFFF, 24'hFFFFFF, 4'd1, 24'hFFFFFE);
    run_op("mul_ff", 2'b00, 24'hFFFFFF, 24'hFFFFFF, 4'd2, 24'h000001);
    run_op("mul_2p24", 2'b00, 24'h001000, 24'h001000, 4'd3, 24'h000000);
    run_op("mulh_2p24", 2'b01, 24'h001000, 24'h001000, 4'd6, 24'h000001);
`ifdef MULDIV_DIV_EN
    run_op("divu_100_7", 2'b10, 24'd100, 24'd7, 4'd7, 24'h00000E);
    run_op("remu_100_7", 2'b11, 24'd100, 24'd7, 4'd8, 24'h000002);
    run_op("divu_by0", 2'b10, 24'h123456, 24'd0, 4'd9, 24'hFFFFFF);
    run_op("remu_by0", 2'b11, 24'h123456, 24'd0, 4'd10, 24'h123456);
`else
    run_op("divu_100_7", 2'b10, 24'd100, 24'd7, 4'd7, 24'h000000);
    run_op("remu_100_7", 2'b11, 24'd100, 24'd7, 4'd8, 24'h000000);
    run_op("divu_by0", 2'b10, 24'h123456, 24'd0, 4'd9, 24'h000000);
    run_op("remu_by0", 2'b11, 24'h123456, 24'd0, 4'd10, 24'h000000);
`endif

    // Reset in the 10th RUN cycle discards the operation.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 24'd11; b = 24'd13; rd_in = 4'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_result", {8'd0, result}, 32'd0);
    check("abort_rd_out", {28'd0, rd_out}, 32'd0);
    dcnt = 0;
    repeat (30) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_no_activity", dcnt, 32'd0);
    run_op("mul_after_rst", 2'b00, 24'd11, 24'd13, 4'd5, 24'd143);

    // Held start: operands change during RUN; second request picked up at k+26.
    @(negedge clk);
    start = 1'b1; op = 2'b00; a = 24'd6; b = 24'd7; rd_in = 4'd2;
    @(posedge clk);
    @(negedge clk);
    a = 24'd9; b = 24'd10; rd_in = 4'd12;
    wait_done("held1", t1);
    check("held1_result", {8'd0, result}, 32'd42);
    check("held1_rd_out", {28'd0, rd_out}, 32'd2);
    @(posedge clk);
    @(negedge clk);
    wait_done("held2", t2);
    start = 1'b0;
    check("held2_result", {8'd0, result}, 32'd90);
    check("held2_rd_out", {28'd0, rd_out}, 32'd12);
    check("held_spacing", t2 - t1, 32'd26);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("held_idle", {30'd0, busy, done}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
